// File: rtl/logic_arbiter.sv
// rtl/logic_arbiter.sv - two-requester round-robin arbiter sharing one bitwise logic unit
//
// Purpose: time-shares a single AND/OR/XOR/NOR unit between two requesters.
//   A 3-state FSM (IDLE -> EXEC -> DONE -> IDLE) captures the winner's operands
//   in IDLE, pulses GrantN in EXEC, registers Result on the EXEC->DONE edge and
//   pulses DoneN in DONE. Fixed latency, one operation per 3 cycles.
//
// Ports:
//   Clk                    rising-edge clock
//   Rst                    synchronous active-high reset
//   Req0, Req1             level requests, held until GrantN
//   OpA0, OpB0, OpA1, OpB1 WIDTH-bit operands per requester
//   Func0, Func1           op code: 00 AND, 01 OR, 10 XOR, 11 NOR
//   Grant0, Grant1         one-cycle pulse: operands captured
//   Done0, Done1           one-cycle pulse: Result holds the answer
//   Result                 registered result of the last completed operation
//   Busy                   high whenever the FSM is not IDLE
module logic_arbiter #(
  parameter int WIDTH = 32
) (
  input  logic             Clk,
  input  logic             Rst,
  input  logic             Req0,
  input  logic             Req1,
  input  logic [WIDTH-1:0] OpA0,
  input  logic [WIDTH-1:0] OpB0,
  input  logic [WIDTH-1:0] OpA1,
  input  logic [WIDTH-1:0] OpB1,
  input  logic [1:0]       Func0,
  input  logic [1:0]       Func1,
  output logic             Grant0,
  output logic             Grant1,
  output logic             Done0,
  output logic             Done1,
  output logic [WIDTH-1:0] Result,
  output logic             Busy
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state;
  state_t           state_next;
  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] op_b;
  logic [1:0]       func;
  logic             winner;
  logic             last_served;
  logic             capture;
  logic             pick;
  logic [WIDTH-1:0] unit_out;

  // Under contention the requester not served last wins; a lone request
  // wins regardless of the pointer (Req1 alone -> 1, otherwise 0).
  always_comb begin
    if (Req0 && Req1) begin
      pick = ~last_served;
    end else begin
      pick = Req1;
    end
  end

  always_comb begin
    case (func)
      2'b00:   unit_out = op_a & op_b;
      2'b01:   unit_out = op_a | op_b;
      2'b10:   unit_out = op_a ^ op_b;
      default: unit_out = ~(op_a | op_b);
    endcase
  end

  always_comb begin
    state_next = state;
    capture    = 1'b0;
    Grant0     = 1'b0;
    Grant1     = 1'b0;
    Done0      = 1'b0;
    Done1      = 1'b0;
    case (state)
      IDLE: begin
        if (Req0 || Req1) begin
          capture    = 1'b1;
          state_next = EXEC;
        end
      end
      EXEC: begin
        Grant0     = ~winner;
        Grant1     = winner;
        state_next = DONE;
      end
      DONE: begin
        Done0      = ~winner;
        Done1      = winner;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  assign Busy = (state != IDLE);

  always_ff @(posedge Clk) begin
    if (Rst) begin
      state       <= IDLE;
      Result      <= '0;
      last_served <= 1'b1;
      winner      <= 1'b0;
      op_a        <= '0;
      op_b        <= '0;
      func        <= 2'b00;
    end else begin
      state <= state_next;
      if (capture) begin
        op_a        <= pick ? OpA1 : OpA0;
        op_b        <= pick ? OpB1 : OpB0;
        func        <= pick ? Func1 : Func0;
        winner      <= pick;
        last_served <= pick;
      end
      // Result only moves on the EXEC->DONE edge, from the latched operands.
      if (state == EXEC) begin
        Result <= unit_out;
      end
    end
  end

endmodule

// File: tb/tb_logic_arbiter.sv
// tb/tb_logic_arbiter.sv - scoreboard testbench for logic_arbiter
module tb_logic_arbiter;
  localparam int W = 32;

  logic         Clk = 1'b0;
  logic         Rst = 1'b1;
  logic         Req0 = 1'b0;
  logic         Req1 = 1'b0;
  logic [W-1:0] OpA0 = '0;
  logic [W-1:0] OpB0 = '0;
  logic [W-1:0] OpA1 = '0;
  logic [W-1:0] OpB1 = '0;
  logic [1:0]   Func0 = 2'b00;
  logic [1:0]   Func1 = 2'b00;
  logic         Grant0;
  logic         Grant1;
  logic         Done0;
  logic         Done1;
  logic [W-1:0] Result;
  logic         Busy;

  logic_arbiter #(.WIDTH(W)) dut (
    .Clk(Clk), .Rst(Rst), .Req0(Req0), .Req1(Req1),
    .OpA0(OpA0), .OpB0(OpB0), .OpA1(OpA1), .OpB1(OpB1),
    .Func0(Func0), .Func1(Func1),
    .Grant0(Grant0), .Grant1(Grant1), .Done0(Done0), .Done1(Done1),
    .Result(Result), .Busy(Busy)
  );

  always #5 Clk = ~Clk;

  int total = 0;
  int bad   = 0;

  typedef struct {
    int           e;
    bit           id;
    logic [W-1:0] res;
  } exp_t;

  exp_t gq[$];
  exp_t dq[$];

  int           edge_n    = 0;
  int           next_free = 0;
  int           cap_edge  = 0;
  int           rst_edge  = -1;
  bit           cap_valid = 1'b0;
  bit           last_srv  = 1'b1;
  bit           mon_en    = 1'b0;
  logic [W-1:0] exp_result = '0;

  function automatic logic [W-1:0] ref_op(input logic [1:0] f, input logic [W-1:0] a,
                                          input logic [W-1:0] b);
    case (f)
      2'd0:    return a & b;
      2'd1:    return a | b;
      2'd2:    return a ^ b;
      default: return ~(a | b);
    endcase
  endfunction

  // Reference model: after a capture at edge t the unit is free again at edge t+3;
  // grant is seen after edge t, done (with result) after edge t+1.
  always @(posedge Clk) begin : model_p
    bit   w;
    exp_t x;
    edge_n++;
    if (Rst) begin
      gq.delete();
      dq.delete();
      last_srv  = 1'b1;
      next_free = edge_n + 1;
      cap_valid = 1'b0;
      rst_edge  = edge_n;
    end else if (edge_n >= next_free && (Req0 || Req1)) begin
      w        = (Req0 && Req1) ? !last_srv : Req1;
      last_srv = w;
      x.id     = w;
      x.e      = edge_n;
      x.res    = w ? ref_op(Func1, OpA1, OpB1) : ref_op(Func0, OpA0, OpB0);
      gq.push_back(x);
      x.e = edge_n + 1;
      dq.push_back(x);
      next_free = edge_n + 3;
      cap_edge  = edge_n;
      cap_valid = 1'b1;
    end
  end

  always @(negedge Clk) begin : mon_p
    exp_t x;
    bit   busy_exp;
    int   e;
    if (mon_en) begin
      e = edge_n;
      if (rst_edge == e) exp_result = '0;
      total++;
      if (Grant0 && Grant1) begin
        bad++;
        $display("FAIL grant_excl e=%0d got=11 exp=not both", e);
      end
      total++;
      if (Done0 && Done1) begin
        bad++;
        $display("FAIL done_excl e=%0d got=11 exp=not both", e);
      end
      if (gq.size() > 0 && gq[0].e <= e) begin
        x = gq.pop_front();
        total++;
        if (x.e != e || Grant0 != !x.id || Grant1 != x.id) begin
          bad++;
          $display("FAIL grant e=%0d got g1g0=%b%b exp id=%0d at e=%0d", e, Grant1, Grant0, x.id, x.e);
        end
      end else if (Grant0 || Grant1) begin
        total++;
        bad++;
        $display("FAIL grant_unexp e=%0d got g1g0=%b%b exp=00", e, Grant1, Grant0);
      end
      if (dq.size() > 0 && dq[0].e <= e) begin
        x = dq.pop_front();
        exp_result = x.res;
        total++;
        if (x.e != e || Done0 != !x.id || Done1 != x.id) begin
          bad++;
          $display("FAIL done e=%0d got d1d0=%b%b exp id=%0d at e=%0d", e, Done1, Done0, x.id, x.e);
        end
      end else if (Done0 || Done1) begin
        total++;
        bad++;
        $display("FAIL done_unexp e=%0d got d1d0=%b%b exp=00", e, Done1, Done0);
      end
      busy_exp = cap_valid && ((e - cap_edge) <= 1);
      total++;
      if (Busy !== busy_exp) begin
        bad++;
        $display("FAIL busy e=%0d got=%b exp=%b", e, Busy, busy_exp);
      end
      total++;
      if (Result !== exp_result) begin
        bad++;
        $display("FAIL result e=%0d got=%h exp=%h", e, Result, exp_result);
      end
    end
  end

  a_gexcl: assert property (@(posedge Clk) disable iff (Rst) !(Grant0 && Grant1))
    else begin bad++; $display("FAIL assert_grant_excl got=both exp=one"); end
  a_dexcl: assert property (@(posedge Clk) disable iff (Rst) !(Done0 && Done1))
    else begin bad++; $display("FAIL assert_done_excl got=both exp=one"); end
  a_g0d0: assert property (@(posedge Clk) disable iff (Rst) Grant0 |=> Done0)
    else begin bad++; $display("FAIL assert_grant0_done0 got=no done exp=done"); end
  a_g1d1: assert property (@(posedge Clk) disable iff (Rst) Grant1 |=> Done1)
    else begin bad++; $display("FAIL assert_grant1_done1 got=no done exp=done"); end

  task automatic do_op(input bit id, input logic [1:0] f, input logic [W-1:0] a,
                       input logic [W-1:0] b, input logic [W-1:0] exp, input string name);
    int waited;
    bit got;
    if (id) begin
      Req1 = 1'b1; Func1 = f; OpA1 = a; OpB1 = b;
    end else begin
      Req0 = 1'b1; Func0 = f; OpA0 = a; OpB0 = b;
    end
    got    = 1'b0;
    waited = 0;
    for (int n = 0; n < 6 && !got; n++) begin
      @(negedge Clk);
      waited++;
      if (id ? Grant1 : Grant0) got = 1'b1;
    end
    total++;
    if (!got || waited != 1) begin
      bad++;
      $display("FAIL %s_grant got=%0d waited=%0d exp=grant after 1", name, got, waited);
    end
    // Drop the request and scramble the operands while the op is in flight.
    Req0 = 1'b0; Req1 = 1'b0;
    OpA0 = $urandom; OpB0 = $urandom; OpA1 = $urandom; OpB1 = $urandom;
    Func0 = 2'($urandom_range(0, 3)); Func1 = 2'($urandom_range(0, 3));
    @(negedge Clk);
    total++;
    if (!(id ? Done1 : Done0) || Result !== exp) begin
      bad++;
      $display("FAIL %s_done got done=%b result=%h exp done=1 result=%h", name,
               id ? Done1 : Done0, Result, exp);
    end
    @(negedge Clk);
    total++;
    if (Busy !== 1'b0) begin
      bad++;
      $display("FAIL %s_idle got busy=%b exp=0", name, Busy);
    end
  endtask

  initial begin : stim
    int gid[$];
    int gcy[$];
    bit got;
    Rst = 1'b1;
    repeat (2) @(posedge Clk);
    mon_en = 1'b1;
    @(negedge Clk);
    Rst = 1'b0;
    total++;
    if ({Grant0, Grant1, Done0, Done1, Busy} !== 5'b0 || Result !== '0) begin
      bad++;
      $display("FAIL reset_state got g0g1d0d1b=%b result=%h exp=00000 0", {Grant0, Grant1, Done0, Done1, Busy}, Result);
    end

    do_op(1'b0, 2'b00, 32'hF0F0F0F0, 32'h0FF00FF0, 32'h00F000F0, "and");
    do_op(1'b1, 2'b01, 32'h0000FFFF, 32'h00FF00FF, 32'h00FFFFFF, "or");
    do_op(1'b1, 2'b10, 32'h0000FFFF, 32'h00FF00FF, 32'h00FFFF00, "xor");
    do_op(1'b1, 2'b11, 32'h0000FFFF, 32'h00FF00FF, 32'hFF000000, "nor");
    do_op(1'b0, 2'b11, 32'h00000000, 32'h00000000, 32'hFFFFFFFF, "nor_zero");

    // Contention held from reset.
    Rst = 1'b1; Req0 = 1'b1; Req1 = 1'b1;
    Func0 = 2'b01; Func1 = 2'b10;
    OpA0 = 32'h12345678; OpB0 = 32'h0F0F0F0F; OpA1 = 32'hAAAA5555; OpB1 = 32'hFFFF0000;
    @(negedge Clk);
    Rst = 1'b0;
    for (int i = 0; i < 13; i++) begin
      @(negedge Clk);
      if (Grant0 || Grant1) begin
        gid.push_back(Grant1 ? 1 : 0);
        gcy.push_back(i);
      end
    end
    Req0 = 1'b0; Req1 = 1'b0;
    total++;
    if (gid.size() < 4) begin
      bad++;
      $display("FAIL contention_count got=%0d exp>=4", gid.size());
    end else begin
      for (int k = 0; k < 4; k++) begin
        total++;
        if (gid[k] != (k % 2) || gcy[k] != 3 * k) begin
          bad++;
          $display("FAIL contention_%0d got id=%0d cyc=%0d exp id=%0d cyc=%0d", k, gid[k], gcy[k], k % 2, 3 * k);
        end
      end
    end
    repeat (3) @(negedge Clk);

    // Reset during EXEC of a Req1 op.
    Req1 = 1'b1; Func1 = 2'b01; OpA1 = 32'h0000FFFF; OpB1 = 32'h00FF00FF;
    got = 1'b0;
    for (int n = 0; n < 6 && !got; n++) begin
      @(negedge Clk);
      if (Grant1) got = 1'b1;
    end
    total++;
    if (!got) begin
      bad++;
      $display("FAIL rst_mid_grant got=none exp=grant1");
    end
    Rst = 1'b1; Req1 = 1'b0;
    @(negedge Clk);
    Rst = 1'b0;
    for (int n = 0; n < 3; n++) begin
      total++;
      if (Done1 || Done0 || Result !== '0) begin
        bad++;
        $display("FAIL rst_mid_abort got d1=%b result=%h exp d1=0 result=0", Done1, Result);
      end
      @(negedge Clk);
    end
    Req0 = 1'b1; Req1 = 1'b1;
    got = 1'b0;
    for (int n = 0; n < 6 && !got; n++) begin
      @(negedge Clk);
      if (Grant0 || Grant1) got = 1'b1;
    end
    total++;
    if (!got || !Grant0 || Grant1) begin
      bad++;
      $display("FAIL rst_first_winner got g1g0=%b%b exp=01", Grant1, Grant0);
    end
    Req0 = 1'b0; Req1 = 1'b0;
    repeat (3) @(negedge Clk);

    // Random traffic, including stray resets and requests held past DONE.
    for (int c = 0; c < 3000; c++) begin
      Req0  = ($urandom_range(0, 2) != 0);
      Req1  = ($urandom_range(0, 2) != 0);
      OpA0  = $urandom; OpB0 = $urandom; OpA1 = $urandom; OpB1 = $urandom;
      Func0 = 2'($urandom_range(0, 3));
      Func1 = 2'($urandom_range(0, 3));
      Rst   = ($urandom_range(0, 99) == 0);
      @(negedge Clk);
    end
    Rst = 1'b0; Req0 = 1'b0; Req1 = 1'b0;
    repeat (5) @(negedge Clk);
    total++;
    if (gq.size() != 0 || dq.size() != 0) begin
      bad++;
      $display("FAIL drain got grants=%0d dones=%0d pending exp=0", gq.size(), dq.size());
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin : watchdog
    #1000000;
    $display("FAIL watchdog got=timeout exp=finish");
    $display("test done: total=%0d bad=%0d", total, bad + 1);
    $fatal(1, "watchdog");
  end

endmodule
